msc_ctrl: RTL and testbench

MSC_CTRL -- requirements
Module: msc_ctrl

---
 rtl/msc_pkg.sv | 16 +
 rtl/msc_port.sv | 80 ++++++++
 rtl/msc_ctrl.sv | 62 ++++++
 tb/tb_msc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/msc_pkg.sv
// rtl/msc_pkg.sv - register map and control bit positions for the memory subsystem controller
package msc_pkg;

    typedef enum logic [1:0] {
        MSC_PRG_CTRL  = 2'd0,
        MSC_PRG_PAGE  = 2'd1,
        MSC_DATA_CTRL = 2'd2,
        MSC_DATA_PAGE = 2'd3
    } msc_addr_e;

    localparam int MSC_BIT_RESET    = 0;
    localparam int MSC_BIT_FLUSH    = 1;
    localparam int MSC_BIT_PREFETCH = 2;
    localparam int MSC_BIT_CTRL_EN  = 3;

endpackage

// File: rtl/msc_port.sv
// rtl/msc_port.sv - one cache port: page register, pending strobes held until idle (MSC_PREFETCH_EN adds prefetch level)
module msc_port
    import msc_pkg::*;
#(
    parameter bit FLUSH_EN = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_page_wr,
    input  logic       i_ctrl_wr,
    input  logic [7:0] i_data,
    input  logic       i_req,
    input  logic       i_ready,
    output logic [7:0] o_page,
    output logic       o_reset,
    output logic       o_flush,
    output logic       o_prefetch
);

    logic [7:0] r_page;
    logic       r_pend_reset;
    logic       r_pend_flush;
    logic       r_reset;
    logic       r_flush;

    logic w_idle;
    logic w_ctrl_ok;
    logic w_want_reset;
    logic w_want_flush;

    // A port is idle when it has no request outstanding or the memory is ready this cycle
    assign w_idle       = ~i_req | i_ready;
    assign w_ctrl_ok    = i_ctrl_wr & i_data[MSC_BIT_CTRL_EN];
    // A new arm merges with an existing pending strobe, so re-arming never yields a second pulse
    assign w_want_reset = r_pend_reset | (w_ctrl_ok & i_data[MSC_BIT_RESET]);
    assign w_want_flush = r_pend_flush | (FLUSH_EN & w_ctrl_ok & i_data[MSC_BIT_FLUSH]);

    // Page load plus strobe generation: fire at the first idle edge, otherwise keep it pending
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_page       <= 8'h00;
            r_pend_reset <= 1'b0;
            r_pend_flush <= 1'b0;
            r_reset      <= 1'b1;
            r_flush      <= 1'b0;
        end else begin
            if (i_page_wr) begin
                r_page <= i_data;
            end
            r_reset      <= w_want_reset & w_idle;
            r_pend_reset <= w_want_reset & ~w_idle;
            r_flush      <= w_want_flush & w_idle;
            r_pend_flush <= w_want_flush & ~w_idle;
        end
    end

    assign o_page  = r_page;
    assign o_reset = r_reset;
    assign o_flush = r_flush;

`ifdef MSC_PREFETCH_EN
    logic r_prefetch;

    // Prefetch enable is a stored level, rewritten by every enabled control write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prefetch <= 1'b0;
        end else if (w_ctrl_ok) begin
            r_prefetch <= i_data[MSC_BIT_PREFETCH];
        end
    end

    assign o_prefetch = r_prefetch;
`else
    logic w_prefetch_unused;
    assign w_prefetch_unused = i_data[MSC_BIT_PREFETCH];
    assign o_prefetch        = 1'b0;
`endif

endmodule

// File: rtl/msc_ctrl.sv
// rtl/msc_ctrl.sv - write-only controller for program and data cache ports (MSC_PREFETCH_EN enables prefetch bits)
module msc_ctrl
    import msc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wren,
    input  logic [1:0] A,
    input  logic [7:0] data,
    input  logic       p1_req,
    input  logic       p1_ready,
    input  logic       p2_req,
    input  logic       p2_ready,
    output logic [7:0] p1_page,
    output logic [7:0] p2_page,
    output logic       p1_reset,
    output logic       p2_reset,
    output logic       p2_flush,
    output logic       p1_prefetch,
    output logic       p2_prefetch
);

    logic w_p1_page_wr;
    logic w_p1_ctrl_wr;
    logic w_p2_page_wr;
    logic w_p2_ctrl_wr;
    logic w_p1_flush_unused;

    assign w_p1_page_wr = wren & (A == MSC_PRG_PAGE);
    assign w_p1_ctrl_wr = wren & (A == MSC_PRG_CTRL);
    assign w_p2_page_wr = wren & (A == MSC_DATA_PAGE);
    assign w_p2_ctrl_wr = wren & (A == MSC_DATA_CTRL);

    msc_port #(.FLUSH_EN(1'b0)) u_prg_port (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_page_wr  (w_p1_page_wr),
        .i_ctrl_wr  (w_p1_ctrl_wr),
        .i_data     (data),
        .i_req      (p1_req),
        .i_ready    (p1_ready),
        .o_page     (p1_page),
        .o_reset    (p1_reset),
        .o_flush    (w_p1_flush_unused),
        .o_prefetch (p1_prefetch)
    );

    msc_port #(.FLUSH_EN(1'b1)) u_data_port (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_page_wr  (w_p2_page_wr),
        .i_ctrl_wr  (w_p2_ctrl_wr),
        .i_data     (data),
        .i_req      (p2_req),
        .i_ready    (p2_ready),
        .o_page     (p2_page),
        .o_reset    (p2_reset),
        .o_flush    (p2_flush),
        .o_prefetch (p2_prefetch)
    );

endmodule

// File: tb/tb_msc_ctrl.sv
// tb/tb_msc_ctrl.sv - self-checking bench for msc_ctrl (expectations follow MSC_PREFETCH_EN)
module tb_msc_ctrl;

    logic       clk;
    logic       rst;
    logic       wren;
    logic [1:0] A;
    logic [7:0] data;
    logic       p1_req, p1_ready, p2_req, p2_ready;
    logic [7:0] p1_page, p2_page;
    logic       p1_reset, p2_reset, p2_flush, p1_prefetch, p2_prefetch;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per port (index 0 = program, 1 = data)
    logic [7:0] m_page [2];
    logic       m_pend_rst [2];
    logic       m_pend_fl [2];
    logic       m_pf [2];
    logic       e_reset [2];
    logic       e_flush;

    msc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .wren        (wren),
        .A           (A),
        .data        (data),
        .p1_req      (p1_req),
        .p1_ready    (p1_ready),
        .p2_req      (p2_req),
        .p2_ready    (p2_ready),
        .p1_page     (p1_page),
        .p2_page     (p2_page),
        .p1_reset    (p1_reset),
        .p2_reset    (p2_reset),
        .p2_flush    (p2_flush),
        .p1_prefetch (p1_prefetch),
        .p2_prefetch (p2_prefetch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the register rules for the inputs presented at the coming edge
    task automatic model_edge();
        logic idle;
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                m_page[n] = 8'h00; m_pend_rst[n] = 1'b0; m_pend_fl[n] = 1'b0;
                m_pf[n] = 1'b0; e_reset[n] = 1'b1;
            end
            e_flush = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                idle = (n == 0) ? (!p1_req || p1_ready) : (!p2_req || p2_ready);
                if (wren && int'(A) == 2 * n + 1) m_page[n] = data;
                if (wren && int'(A) == 2 * n && data[3]) begin
                    if (data[0]) m_pend_rst[n] = 1'b1;
                    if (n == 1 && data[1]) m_pend_fl[n] = 1'b1;
`ifdef MSC_PREFETCH_EN
                    m_pf[n] = data[2];
`endif
                end
                e_reset[n] = m_pend_rst[n] && idle;
                if (n == 1) e_flush = m_pend_fl[n] && idle;
                if (idle) begin
                    m_pend_rst[n] = 1'b0;
                    m_pend_fl[n]  = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk8({tag, ".p1_page"}, p1_page, m_page[0]);
        chk8({tag, ".p2_page"}, p2_page, m_page[1]);
        chk1({tag, ".p1_reset"}, p1_reset, e_reset[0]);
        chk1({tag, ".p2_reset"}, p2_reset, e_reset[1]);
        chk1({tag, ".p2_flush"}, p2_flush, e_flush);
        chk1({tag, ".p1_prefetch"}, p1_prefetch, m_pf[0]);
        chk1({tag, ".p2_prefetch"}, p2_prefetch, m_pf[1]);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wren = 1'b1; A = a; data = d;
    endtask

    logic exp_pf;

    initial begin
        rst = 1'b1; wren = 1'b0; A = 2'd0; data = 8'h00;
        p1_req = 1'b0; p1_ready = 1'b0; p2_req = 1'b0; p2_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_page[n] = 8'h00; m_pend_rst[n] = 1'b0; m_pend_fl[n] = 1'b0;
            m_pf[n] = 1'b0; e_reset[n] = 1'b1;
        end
        e_flush = 1'b0;

        // Reset held three cycles, writes ignored
        wr(2'd1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step("rst");
            chk1("rst_p1_reset", p1_reset, 1'b1);
            chk1("rst_p2_reset", p2_reset, 1'b1);
            chk8("rst_p1_page", p1_page, 8'h00);
        end
        rst = 1'b0; wren = 1'b0;
        step("post_rst");
        chk1("post_rst_p1_reset", p1_reset, 1'b0);
        chk1("post_rst_p2_reset", p2_reset, 1'b0);

        // Page writes
        wr(2'd1, 8'h5A); step("pg1");
        wr(2'd3, 8'hC3); step("pg2");
        wren = 1'b0;
        chk8("page_p1", p1_page, 8'h5A);
        chk8("page_p2", p2_page, 8'hC3);

        // Control write without enable does nothing
        wr(2'd2, 8'h01); step("noen");
        chk1("noen_p2_reset", p2_reset, 1'b0);
        wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("noen_idle");
            chk1("noen_idle_p2_reset", p2_reset, 1'b0);
        end

        // Reset+flush on idle port 2 pulse together for one cycle
        wr(2'd2, 8'h0B); step("rf");
        chk1("rf_p2_reset", p2_reset, 1'b1);
        chk1("rf_p2_flush", p2_flush, 1'b1);
        wren = 1'b0; step("rf_after");
        chk1("rf_after_p2_reset", p2_reset, 1'b0);
        chk1("rf_after_p2_flush", p2_flush, 1'b0);

        // Busy port 1 defers its reset; port 2 still fires immediately
        p1_req = 1'b1; p1_ready = 1'b0;
        wr(2'd0, 8'h09); step("p1busy_arm");
        chk1("p1busy_arm_p1_reset", p1_reset, 1'b0);
        wr(2'd2, 8'h09); step("p2_indep");
        chk1("p2_indep_p2_reset", p2_reset, 1'b1);
        chk1("p2_indep_p1_reset", p1_reset, 1'b0);
        wr(2'd0, 8'h09); step("p1_rearm");
        wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("p1busy");
            chk1("p1busy_p1_reset", p1_reset, 1'b0);
        end
        p1_ready = 1'b1; step("p1_ready");
        chk1("p1_ready_p1_reset", p1_reset, 1'b1);
        step("p1_done");
        chk1("p1_done_p1_reset", p1_reset, 1'b0);
        p1_req = 1'b0; p1_ready = 1'b0;

        // Pending flush discarded by reset
        p2_req = 1'b1; p2_ready = 1'b0;
        wr(2'd2, 8'h0A); step("fl_arm");
        wren = 1'b0; step("fl_wait");
        rst = 1'b1; step("fl_rst");
        rst = 1'b0; p2_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("fl_gone");
            chk1("fl_gone_p2_flush", p2_flush, 1'b0);
        end
        p2_req = 1'b0; p2_ready = 1'b0;

        // Prefetch enable level
`ifdef MSC_PREFETCH_EN
        exp_pf = 1'b1;
`else
        exp_pf = 1'b0;
`endif
        wr(2'd0, 8'h0C); step("pf_on");
        wren = 1'b0; step("pf_hold");
        chk1("pf_hold_p1_prefetch", p1_prefetch, exp_pf);
        step("pf_hold2");
        chk1("pf_hold2_p1_prefetch", p1_prefetch, exp_pf);
        wr(2'd0, 8'h08); step("pf_off");
        wren = 1'b0;
        chk1("pf_off_p1_prefetch", p1_prefetch, 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wren     = ($urandom_range(0, 2) != 0);
            A        = 2'($urandom_range(0, 3));
            data     = 8'($urandom);
            p1_req   = ($urandom_range(0, 2) != 0);
            p1_ready = ($urandom_range(0, 3) == 0);
            p2_req   = ($urandom_range(0, 2) != 0);
            p2_ready = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
